// File: rtl/nx_output_reporter_pkg.sv
// Shared constants and types for the output-reporting path.
package NXConstants;

  localparam int unsigned NX_OUTPUTS     = 32;
  localparam int unsigned NX_SLICE_WIDTH = 8;
  localparam int unsigned NX_CYCLE_WIDTH = 16;

  // Index width for a slice count, kept at least one bit wide.
  function automatic int unsigned index_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned NX_INDEX_WIDTH = index_width(NX_OUTPUTS / NX_SLICE_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    SEND
  } reporter_state_t;

  // Report message layout at the default widths, as seen by the host link.
  typedef struct packed {
    logic [NX_CYCLE_WIDTH-1:0] cycle;
    logic [NX_INDEX_WIDTH-1:0] index;
    logic [NX_SLICE_WIDTH-1:0] data;
  } output_report_t;

endpackage

// File: rtl/nx_output_reporter_slicer.sv
// Selects one slice of the snapshot and flags whether it differs from what was last reported.
module nx_report_slicer
  import NXConstants::*;
#(
  parameter int unsigned OUTPUTS     = NX_OUTPUTS,
  parameter int unsigned SLICE_WIDTH = NX_SLICE_WIDTH,
  localparam int unsigned NSLICES    = OUTPUTS / SLICE_WIDTH,
  localparam int unsigned IDX_W      = index_width(NSLICES)
) (
  input  logic [OUTPUTS-1:0]     i_snapshot,
  input  logic [OUTPUTS-1:0]     i_last_sent,
  input  logic [IDX_W-1:0]       i_index,
  output logic [SLICE_WIDTH-1:0] o_slice,
  output logic                   o_changed
);

  logic [SLICE_WIDTH-1:0] prev_slice;

  // Mux the indexed slice out of both vectors and compare them.
  always_comb begin
    o_slice    = '0;
    prev_slice = '0;
    for (int unsigned i = 0; i < NSLICES; i++) begin
      if (IDX_W'(i) == i_index) begin
        o_slice    = i_snapshot[i*SLICE_WIDTH +: SLICE_WIDTH];
        prev_slice = i_last_sent[i*SLICE_WIDTH +: SLICE_WIDTH];
      end
    end
    o_changed = (o_slice != prev_slice);
  end

endmodule

// File: rtl/nx_output_reporter.sv
// Snapshots the aggregated outputs at end of mesh cycle and streams one
// report per slice that changed since the previous report.
module nx_output_reporter
  import NXConstants::*;
#(
  parameter int unsigned OUTPUTS     = NX_OUTPUTS,
  parameter int unsigned SLICE_WIDTH = NX_SLICE_WIDTH,
  parameter int unsigned CYCLE_WIDTH = NX_CYCLE_WIDTH,
  localparam int unsigned NSLICES    = OUTPUTS / SLICE_WIDTH,
  localparam int unsigned IDX_W      = index_width(NSLICES),
  localparam int unsigned REPORT_W   = CYCLE_WIDTH + IDX_W + SLICE_WIDTH
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [OUTPUTS-1:0]  i_outputs,
  input  logic                i_trigger,
  input  logic                i_force_all,
  output logic [REPORT_W-1:0] o_report_data,
  output logic                o_report_valid,
  input  logic                i_report_ready,
  output logic                o_busy,
  output logic                o_overflow
);

  typedef struct packed {
    logic [CYCLE_WIDTH-1:0] cycle;
    logic [IDX_W-1:0]       index;
    logic [SLICE_WIDTH-1:0] data;
  } report_t;

  reporter_state_t        state_q, state_d;
  logic [IDX_W-1:0]       slice_q, slice_d;
  logic [CYCLE_WIDTH-1:0] cycle_q, cycle_d;
  logic [OUTPUTS-1:0]     snapshot_q, snapshot_d;
  logic [OUTPUTS-1:0]     last_sent_q, last_sent_d;
  report_t                report_q, report_d;
  logic                   force_q, force_d;
  logic                   first_q, first_d;
  logic                   pending_q, pending_d;
  logic                   overflow_q, overflow_d;

  logic [SLICE_WIDTH-1:0] slice_bits;
  logic                   slice_changed;
  logic                   last_slice;

  nx_report_slicer #(
    .OUTPUTS     (OUTPUTS),
    .SLICE_WIDTH (SLICE_WIDTH)
  ) u_slicer (
    .i_snapshot  (snapshot_q),
    .i_last_sent (last_sent_q),
    .i_index     (slice_q),
    .o_slice     (slice_bits),
    .o_changed   (slice_changed)
  );

  assign last_slice = (slice_q == IDX_W'(NSLICES - 1));

  // Next-state logic: snapshot start, per-slice scan, and report handshake.
  always_comb begin
    state_d     = state_q;
    slice_d     = slice_q;
    cycle_d     = cycle_q;
    snapshot_d  = snapshot_q;
    last_sent_d = last_sent_q;
    report_d    = report_q;
    force_d     = force_q;
    first_d     = first_q;
    pending_d   = pending_q;
    overflow_d  = overflow_q;

    case (state_q)
      IDLE: begin
        if (i_trigger || pending_q) begin
          snapshot_d = i_outputs;
          cycle_d    = cycle_q + 1'b1;
          first_d    = 1'b0;
          slice_d    = '0;
          state_d    = SCAN;
          // A deferred trigger runs first and never carries force; a fresh
          // trigger arriving alongside it is deferred in turn.
          if (pending_q) begin
            force_d   = first_q;
            pending_d = i_trigger;
          end else begin
            force_d   = i_force_all | first_q;
          end
        end
      end
      SCAN: begin
        if (force_q || slice_changed) begin
          report_d = '{cycle: cycle_q, index: slice_q, data: slice_bits};
          for (int unsigned i = 0; i < NSLICES; i++) begin
            if (IDX_W'(i) == slice_q) begin
              last_sent_d[i*SLICE_WIDTH +: SLICE_WIDTH] = slice_bits;
            end
          end
          state_d = SEND;
        end else if (last_slice) begin
          state_d = IDLE;
        end else begin
          slice_d = slice_q + 1'b1;
        end
      end
      SEND: begin
        if (i_report_ready) begin
          if (last_slice) begin
            state_d = IDLE;
          end else begin
            slice_d = slice_q + 1'b1;
            state_d = SCAN;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && i_trigger) begin
      if (pending_q) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      slice_q     <= '0;
      cycle_q     <= '0;
      snapshot_q  <= '0;
      last_sent_q <= '0;
      report_q    <= '0;
      force_q     <= 1'b0;
      first_q     <= 1'b1;
      pending_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slice_q     <= slice_d;
      cycle_q     <= cycle_d;
      snapshot_q  <= snapshot_d;
      last_sent_q <= last_sent_d;
      report_q    <= report_d;
      force_q     <= force_d;
      first_q     <= first_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
    end
  end

  assign o_report_valid = (state_q == SEND);
  assign o_report_data  = report_q;
  assign o_busy         = (state_q != IDLE) || pending_q;
  assign o_overflow     = overflow_q;

endmodule

// File: tb/tb_nx_output_reporter.sv
// Self-checking bench for nx_output_reporter against a slice-delta reference model.
module tb_nx_output_reporter;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_outputs;
  logic        i_trigger;
  logic        i_force_all;
  logic [25:0] o_report_data;
  logic        o_report_valid;
  logic        i_report_ready;
  logic        o_busy;
  logic        o_overflow;

  // Narrow-counter instance used to exercise cycle wrap-around cheaply.
  logic [31:0] w_outputs = 32'h1234_5678;
  logic        w_trigger;
  logic        w_force;
  logic [13:0] w_data;
  logic        w_valid;
  logic        w_ready = 1'b1;
  logic        w_busy;
  logic        w_overflow;

  int checks = 0;
  int errors = 0;

  logic [25:0] got_q[$];
  logic [25:0] exp_q[$];
  logic [13:0] w_q[$];

  logic [7:0]  m_last[4];
  logic [15:0] m_cycle;
  bit          m_first;
  int          busy_cycles;

  always #5 clk = ~clk;

  nx_output_reporter #(
    .OUTPUTS     (32),
    .SLICE_WIDTH (8),
    .CYCLE_WIDTH (16)
  ) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_outputs      (i_outputs),
    .i_trigger      (i_trigger),
    .i_force_all    (i_force_all),
    .o_report_data  (o_report_data),
    .o_report_valid (o_report_valid),
    .i_report_ready (i_report_ready),
    .o_busy         (o_busy),
    .o_overflow     (o_overflow)
  );

  nx_output_reporter #(
    .OUTPUTS     (32),
    .SLICE_WIDTH (8),
    .CYCLE_WIDTH (4)
  ) dut_w (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_outputs      (w_outputs),
    .i_trigger      (w_trigger),
    .i_force_all    (w_force),
    .o_report_data  (w_data),
    .o_report_valid (w_valid),
    .i_report_ready (w_ready),
    .o_busy         (w_busy),
    .o_overflow     (w_overflow)
  );

  // Record every accepted report; handshake completes at the following rising edge.
  always @(negedge clk) begin
    if (o_report_valid && i_report_ready) got_q.push_back(o_report_data);
    if (w_valid && w_ready) w_q.push_back(w_data);
  end

  task automatic model_reset();
    m_cycle = '0;
    m_first = 1'b1;
    for (int s = 0; s < 4; s++) m_last[s] = '0;
  endtask

  // A snapshot reports every byte that differs from what the host last saw.
  task automatic model_snapshot(input logic [31:0] v, input bit f);
    logic [7:0] b;
    m_cycle = m_cycle + 16'd1;
    for (int s = 0; s < 4; s++) begin
      b = v[s*8 +: 8];
      if (f || m_first || b != m_last[s]) begin
        exp_q.push_back({m_cycle, 2'(s), b});
        m_last[s] = b;
      end
    end
    m_first = 1'b0;
  endtask

  task automatic run_snapshot(input logic [31:0] v, input bit f, input bit rnd_ready);
    int n;
    @(posedge clk); #1;
    i_outputs   = v;
    i_force_all = f;
    i_trigger   = 1'b1;
    model_snapshot(v, f);
    @(posedge clk); #1;
    i_trigger   = 1'b0;
    i_force_all = 1'b0;
    n = 0;
    while (o_busy && n < 200) begin
      i_report_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      i_outputs      = $urandom();
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (o_busy) begin
      errors++;
      $display("FAIL busy_timeout: busy=%0b after %0d cycles, required 0", o_busy, n);
    end
    i_report_ready = 1'b1;
    busy_cycles    = n;
  endtask

  task automatic test_reset();
    checks += 4;
    if (o_report_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b, required 0", o_report_valid); end
    if (o_report_data !== '0) begin errors++; $display("FAIL reset_data: got %h, required 0", o_report_data); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b, required 0", o_busy); end
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b, required 0", o_overflow); end
  endtask

  task automatic test_first_report();
    got_q.delete(); exp_q.delete();
    run_snapshot(32'h0000_00A5, 1'b0, 1'b1);
    checks += 2;
    if (got_q.size() !== 4) begin errors++; $display("FAIL first_count: got %0d reports, required 4", got_q.size()); end
    if (got_q[0] !== {16'd1, 2'd0, 8'hA5}) begin errors++; $display("FAIL first_idx0: got %h, required %h", got_q[0], {16'd1, 2'd0, 8'hA5}); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL first_report[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_single_delta();
    got_q.delete(); exp_q.delete();
    run_snapshot(32'h0100_00A5, 1'b0, 1'b1);
    checks += 2;
    if (got_q.size() !== 1) begin errors++; $display("FAIL delta_count: got %0d reports, required 1", got_q.size()); end
    if (got_q[0] !== {16'd2, 2'd3, 8'h01}) begin errors++; $display("FAIL delta_report: got %h, required %h", got_q[0], {16'd2, 2'd3, 8'h01}); end
  endtask

  task automatic test_no_change();
    got_q.delete(); exp_q.delete();
    run_snapshot(32'h0100_00A5, 1'b0, 1'b1);
    checks += 2;
    if (got_q.size() !== 0) begin errors++; $display("FAIL nochange_count: got %0d reports, required 0", got_q.size()); end
    // One scan cycle per unchanged slice.
    if (busy_cycles !== 4) begin errors++; $display("FAIL nochange_busy: busy %0d cycles, required 4", busy_cycles); end
  endtask

  task automatic test_backpressure();
    int n;
    got_q.delete(); exp_q.delete();
    i_report_ready = 1'b0;
    @(posedge clk); #1;
    i_outputs = 32'h0122_00A6;
    i_trigger = 1'b1;
    model_snapshot(32'h0122_00A6, 1'b0);
    @(posedge clk); #1;
    i_trigger = 1'b0;
    n = 0;
    while (!o_report_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== 1) begin errors++; $display("FAIL first_valid_latency: valid after %0d cycles, required 1", n); end
    for (int c = 0; c < 10; c++) begin
      i_outputs = $urandom();
      checks += 2;
      if (o_report_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %0b, required 1", c, o_report_valid); end
      if (o_report_data !== exp_q[0]) begin errors++; $display("FAIL stall_data[%0d]: got %h, required %h", c, o_report_data, exp_q[0]); end
      @(posedge clk); #1;
    end
    checks++;
    if (got_q.size() !== 0) begin errors++; $display("FAIL stall_accepted: got %0d reports, required 0", got_q.size()); end
    i_report_ready = 1'b1;
    n = 0;
    while (o_busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL stall_count: got %0d reports, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL stall_report[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_pending_overflow();
    logic [31:0] a;
    logic [31:0] b;
    int n;
    got_q.delete(); exp_q.delete();
    for (int s = 0; s < 4; s++) a[s*8 +: 8] = ~m_last[s];
    b = $urandom();
    i_report_ready = 1'b1;
    @(posedge clk); #1;
    i_outputs = a;
    i_trigger = 1'b1;
    model_snapshot(a, 1'b0);
    @(posedge clk); #1; i_trigger = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; i_outputs = b; i_trigger = 1'b1;
    @(posedge clk); #1; i_trigger = 1'b0;
    @(posedge clk); #1; i_trigger = 1'b1;
    @(posedge clk); #1; i_trigger = 1'b0;
    model_snapshot(b, 1'b0);
    checks += 2;
    if (o_overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %0b, required 1", o_overflow); end
    if (o_busy !== 1'b1) begin errors++; $display("FAIL pending_busy: got %0b, required 1", o_busy); end
    n = 0;
    while (o_busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL pending_count: got %0d reports, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL pending_report[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_send();
    int n;
    logic [31:0] v;
    for (int s = 0; s < 4; s++) v[s*8 +: 8] = m_last[s];
    v[23:16] = ~v[23:16];
    got_q.delete(); exp_q.delete();
    checks++;
    if (o_overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %0b, required 1", o_overflow); end
    i_report_ready = 1'b0;
    @(posedge clk); #1;
    i_outputs = v;
    i_trigger = 1'b1;
    @(posedge clk); #1; i_trigger = 1'b0;
    n = 0;
    while (!o_report_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (o_report_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %0b, required 1", o_report_valid); end
    #2;
    i_rst = 1'b1;
    #1;
    checks += 4;
    if (o_report_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %0b, required 0", o_report_valid); end
    if (o_report_data !== '0) begin errors++; $display("FAIL async_reset_data: got %h, required 0", o_report_data); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %0b, required 0", o_busy); end
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL async_reset_overflow: got %0b, required 0", o_overflow); end
    @(negedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    model_reset();
    got_q.delete(); exp_q.delete();
    run_snapshot(32'h0000_0000, 1'b0, 1'b1);
    checks += 2;
    if (got_q.size() !== 4) begin errors++; $display("FAIL post_reset_count: got %0d reports, required 4", got_q.size()); end
    if (got_q[0] !== {16'd1, 2'd0, 8'h00}) begin errors++; $display("FAIL post_reset_idx0: got %h, required %h", got_q[0], {16'd1, 2'd0, 8'h00}); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL post_reset_report[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_cycle_wrap();
    int n;
    logic [13:0] exp_w;
    w_q.delete();
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      w_trigger = 1'b1;
      w_force   = (k == 16);
      @(posedge clk); #1;
      w_trigger = 1'b0;
      w_force   = 1'b0;
      n = 0;
      while (w_busy && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      checks++;
      if (w_busy) begin errors++; $display("FAIL wrap_busy_timeout: trigger %0d still busy", k); end
    end
    checks++;
    if (w_q.size() !== 8) begin errors++; $display("FAIL wrap_count: got %0d reports, required 8", w_q.size()); end
    for (int s = 0; s < 4; s++) begin
      exp_w = {4'(16), 2'(s), w_outputs[s*8 +: 8]};
      checks++;
      if (w_q[4 + s] !== exp_w) begin errors++; $display("FAIL wrap_report[%0d]: got %h, required %h", s, w_q[4 + s], exp_w); end
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    bit f;
    for (int it = 0; it < 40; it++) begin
      got_q.delete(); exp_q.delete();
      v = $urandom();
      for (int s = 0; s < 4; s++) if ($urandom_range(0, 1) == 0) v[s*8 +: 8] = m_last[s];
      f = ($urandom_range(0, 9) == 0);
      run_snapshot(v, f, 1'b1);
      checks++;
      if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count[%0d]: got %0d reports, required %0d", it, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand_report[%0d.%0d]: got %h, required %h", it, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    i_rst          = 1'b1;
    i_outputs      = '0;
    i_trigger      = 1'b0;
    i_force_all    = 1'b0;
    i_report_ready = 1'b1;
    w_trigger      = 1'b0;
    w_force        = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    test_reset();
    i_rst = 1'b0;
    test_first_report();
    test_single_delta();
    test_no_change();
    test_backpressure();
    test_random();
    test_pending_overflow();
    test_reset_mid_send();
    test_cycle_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
